// File: rtl/pipe_pkg.sv
// Shared tag type and sizing helpers for the pipeline scoreboard/forwarding controller.
// Optional define SCB_ZERO_REG_EN makes register 0 a hardwired zero.
package pipe_pkg;

  // Tag rd field is fixed-width so the struct can live in a package; covers NREG up to 256.
  localparam int TAG_RD_W = 8;
  localparam int FWD_RF   = 0;

`ifdef SCB_ZERO_REG_EN
  localparam bit ZERO_REG_HARD = 1'b1;
`else
  localparam bit ZERO_REG_HARD = 1'b0;
`endif

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } tag_t;

  function automatic int reg_aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/scb_operand_resolve.sv
// Per-operand priority match over the in-flight tags: youngest producer wins.
// Honours SCB_ZERO_REG_EN (via pipe_pkg) so source register 0 never matches.
module scb_operand_resolve
  import pipe_pkg::*;
#(
  parameter int DEPTH            = 3,
  parameter int REG_AW           = 3,
  parameter int SEL_W            = 2,
  parameter int LOAD_READY_STAGE = 2
) (
  input  tag_t [DEPTH:1]    tags_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              use_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              needs_stall_o
);

  logic src_live;
  logic found;

  assign src_live = use_i && !(ZERO_REG_HARD && (rs_i == '0));

  always_comb begin
    sel_o         = SEL_W'(FWD_RF);
    needs_stall_o = 1'b0;
    found         = 1'b0;
    for (int s = 1; s <= DEPTH; s++) begin
      if (!found && src_live && tags_i[s].valid && tags_i[s].regwrite &&
          (tags_i[s].rd == TAG_RD_W'(rs_i))) begin
        found         = 1'b1;
        sel_o         = SEL_W'(s);
        needs_stall_o = tags_i[s].is_load && (s < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard_fwd.sv
// ID-stage hazard detector and operand forwarder tracking DEPTH post-decode stages.
// Optional define SCB_ZERO_REG_EN: register 0 hardwired zero (no match, no stall, operand 0).
module pipe_scoreboard_fwd
  import pipe_pkg::*;
#(
  parameter int  DATA_W           = 8,
  parameter int  NREG             = 8,
  parameter int  DEPTH            = 3,
  parameter int  LOAD_READY_STAGE = 2,
  parameter int  CNT_W            = 16,
  localparam int REG_AW           = reg_aw(NREG),
  localparam int SEL_W            = sel_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [REG_AW-1:0]       id_rs1,
  input  logic [REG_AW-1:0]       id_rs2,
  input  logic                    id_use_rs1,
  input  logic                    id_use_rs2,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_regwrite,
  input  logic                    id_is_load,
  input  logic [DATA_W-1:0]       rf_rd1,
  input  logic [DATA_W-1:0]       rf_rd2,
  input  logic [DEPTH*DATA_W-1:0] stage_res,
  input  logic                    flush,
  output logic                    stall,
  output logic [SEL_W-1:0]        fwd_sel_a,
  output logic [SEL_W-1:0]        fwd_sel_b,
  output logic [DATA_W-1:0]       opnd_a,
  output logic [DATA_W-1:0]       opnd_b,
  output logic [CNT_W-1:0]        stall_cnt
);

  tag_t [DEPTH:1]   tags_q, tags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             need_a, need_b;

  scb_operand_resolve #(
    .DEPTH(DEPTH), .REG_AW(REG_AW), .SEL_W(SEL_W), .LOAD_READY_STAGE(LOAD_READY_STAGE)
  ) u_res_a (
    .tags_i(tags_q), .rs_i(id_rs1), .use_i(id_use_rs1),
    .sel_o(fwd_sel_a), .needs_stall_o(need_a)
  );

  scb_operand_resolve #(
    .DEPTH(DEPTH), .REG_AW(REG_AW), .SEL_W(SEL_W), .LOAD_READY_STAGE(LOAD_READY_STAGE)
  ) u_res_b (
    .tags_i(tags_q), .rs_i(id_rs2), .use_i(id_use_rs2),
    .sel_o(fwd_sel_b), .needs_stall_o(need_b)
  );

  // Flush overrides any hazard: the killed instruction must not hold the front end.
  assign stall = id_valid && !flush && (need_a || need_b);

  always_comb begin
    opnd_a = rf_rd1;
    opnd_b = rf_rd2;
    for (int s = 1; s <= DEPTH; s++) begin
      if (fwd_sel_a == SEL_W'(s)) opnd_a = stage_res[s*DATA_W-1 -: DATA_W];
      if (fwd_sel_b == SEL_W'(s)) opnd_b = stage_res[s*DATA_W-1 -: DATA_W];
    end
    if (ZERO_REG_HARD && (id_rs1 == '0)) opnd_a = '0;
    if (ZERO_REG_HARD && (id_rs2 == '0)) opnd_b = '0;
  end

  always_comb begin
    tags_d = tags_q;
    for (int s = 2; s <= DEPTH; s++) tags_d[s] = tags_q[s-1];
    if (flush || stall || !id_valid) begin
      tags_d[1] = '0;
    end else begin
      tags_d[1].valid    = 1'b1;
      tags_d[1].rd       = TAG_RD_W'(id_rd);
      tags_d[1].regwrite = id_regwrite;
      tags_d[1].is_load  = id_is_load;
    end
  end

  assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tags_q <= '0;
      cnt_q  <= '0;
    end else begin
      tags_q <= tags_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: doc/pipe_scoreboard_fwd.md
Name: pipe_scoreboard_fwd

Overview:
Parametrised hazard/forwarding controller for the pipelined core; successor to the fixed 8-bit/8-register load-use detector plus EX-stage forward unit. Sits at operand-read (ID) point and tracks in-flight destination tags through DEPTH post-decode stages (1=EX … DEPTH=WB). Emits stall, per-operand forward selects and the final forwarded operands. Adds configurable load-ready stage, flush handling, and a stall counter.

Parameters:
DATA_W, 8, operand/result width
NREG, 8, architectural registers; REG_AW = clog2(NREG)
DEPTH, 3, tracked stages after ID (EX, MEM, WB)
LOAD_READY_STAGE, 2, first stage whose result bus carries load data (2..DEPTH)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  REG_AW  source registers
id_use_rs1, id_use_rs2  in  1  operand actually read
id_rd  in  REG_AW  destination
id_regwrite  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
rf_rd1, rf_rd2  in  DATA_W  register-file read data
stage_res  in  DEPTH*DATA_W  result bus of stage s at [s*DATA_W-1 -: DATA_W]
flush  in  1  kill ID instruction (branch mispredict)
stall  out  1  hold IF/ID, bubble into EX
fwd_sel_a, fwd_sel_b  out  clog2(DEPTH+1)  0=RF, s=stage s
opnd_a, opnd_b  out  DATA_W  forwarded operands
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (sync, clk edge with reset=1): all tag entries invalid, stall_cnt=0; outputs then stall=0, fwd_sel=0, opnd=rf data. Reset mid-operation discards all in-flight tags same edge.
- Tag entry per stage s: {valid, rd, regwrite, is_load}. Every edge: entry s+1 <= entry s for s=1..DEPTH-1; entry DEPTH dropped.
- Entry 1 load: if flush or stall or !id_valid -> bubble (valid=0); else ID fields.
- Match(s, r) = valid_s & regwrite_s & rd_s==r. Per operand choose smallest s matching (youngest producer); none -> sel 0.
- Ready(s) = !is_load_s | s >= LOAD_READY_STAGE.
- stall = id_valid & !flush & OR over operands(use & youngest match exists & !Ready(s)). Combinational, same cycle.
- Forward: opnd = sel==0 ? rf_rd : stage_res[sel]. Stage DEPTH (WB) is still forwarded (RF write lands at end of cycle).
- Unused operand (use=0): sel=0, never stalls.
- flush and stall same cycle: flush wins, stall=0, bubble inserted.
- Load-use with LOAD_READY_STAGE=2: exactly one stall cycle, then forward from stage 2.
- stall_cnt increments each cycle stall=1; saturates at all-ones.
- Latency: stall/sel/opnd combinational from inputs; tags registered, 1 cycle per stage.

Optional Feature:
SCB_ZERO_REG_EN: defined -> register 0 hardwired zero: rd==0 never matches, source 0 never stalls, opnd forced 0 when rs==0. Undefined -> register 0 is ordinary (current core behaviour).

Decomposition:
- Package pipe_pkg: tag entry struct (valid, rd, regwrite, is_load), FWD_RF=0 constant, REG_AW/SEL_W derivation functions.
- Sub-module scb_operand_resolve (instantiated twice): priority match over DEPTH entries, returns sel and needs_stall.

Test Plan:
- ADD r3 in EX, ID reads rs1=r3, stage_res[1]=0x2A -> fwd_sel_a=1, opnd_a=0x2A, stall=0.
- LOAD r2 in EX, ID reads rs2=r2 -> stall=1 one cycle, EX bubble; next cycle fwd_sel_b=2, opnd_b=stage_res[2]; stall_cnt=1.
- r5 written in both EX (0x11) and WB (0x77), ID reads r5 -> sel=1, opnd=0x11 (youngest wins).
- Load-use hazard with flush=1 same cycle -> stall=0, entry 1 bubble, stall_cnt unchanged.
- 70000 consecutive forced stalls (CNT_W=16) -> stall_cnt holds 0xFFFF; reset=1 one edge -> stall_cnt=0, all sel=0.
- SCB_ZERO_REG_EN defined, LOAD r0 in EX, ID reads r0 -> stall=0, opnd=0x00.
